req_ack_responder: RTL

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

---
 rtl/req_ack_pkg.sv | 23 ++
 rtl/req_ack_fifo.sv | 66 ++++++
 rtl/req_ack_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// rtl/req_ack_pkg.sv - shared types and constants for the request/acknowledge responder
// Contents:
//   state_t     controller state encoding (IDLE / WAIT / ACK)
//   CNT_W       width of the head delay counter
//   delay_load  value loaded into the delay counter when an entry becomes head
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // The counter covers the WAIT cycles only: an entry that becomes head
    // spends ack_delay-1 cycles in WAIT (counter ack_delay-2 down to 0)
    // before the ACK cycle. A delay of 1 skips WAIT entirely.
    function automatic logic [CNT_W-1:0] delay_load(input int ack_delay);
        return (ack_delay >= 2) ? CNT_W'(ack_delay - 2) : '0;
    endfunction

endpackage

// File: rtl/req_ack_fifo.sv
// rtl/req_ack_fifo.sv - in-order payload FIFO for outstanding requests
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wdata   write request and payload (taken when not full or popping)
//   pop, rdata    read request; rdata shows the head entry combinationally
//   level         registered occupancy, 0..DEPTH
//   full, empty   occupancy flags
module req_ack_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/req_ack_responder.sv
// rtl/req_ack_responder.sv - buffers request pulses and answers each with a delayed ack pulse
// Ports:
//   clk, reset_l   clock, asynchronous active-low reset
//   bus_req        single-cycle request strobe, bus_data valid alongside
//   bus_data       request payload
//   bus_ack        single-cycle acknowledge, one per accepted request, in order
//   ack_data       payload of the acknowledged request, zero otherwise
//   busy           a request is outstanding
//   level          number of outstanding requests
//   overflow_err   sticky: a request was dropped because the buffer was full
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       bus_req,
    input  logic [DW-1:0]              bus_data,
    output logic                       bus_ack,
    output logic [DW-1:0]              ack_data,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow_err
);

    localparam int LW = $clog2(DEPTH + 1);
    // With a one-cycle delay an entry that becomes head is acked immediately.
    localparam state_t           FIRST = (ACK_DELAY == 1) ? ACK : WAIT;
    localparam logic [CNT_W-1:0] LOAD  = delay_load(ACK_DELAY);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       run_q;
    logic             run;
    logic             pop;
    logic             accept;
    logic             fifo_full;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_rdata;

    // Release of reset is retimed through two flops; requests are ignored
    // until it has propagated, so the first acceptance is at least two
    // edges after release.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            run_q <= '0;
        end else begin
            run_q <= {run_q[0], 1'b1};
        end
    end
    assign run = run_q[1];

    assign pop    = (state_q == ACK);
    assign accept = run && bus_req && (!fifo_full || pop);

    req_ack_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_l),
        .push  (accept),
        .pop   (pop),
        .wdata (bus_data),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            overflow_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (run && bus_req && !accept) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FIRST;
                    cnt_d   = LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                // The next entry becomes head now; its delay starts from this
                // ack, which also covers a request pushed in this same cycle.
                if (accept || (!fifo_empty && level != LW'(1))) begin
                    state_d = FIRST;
                    cnt_d   = LOAD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus_ack  = (state_q == ACK);
    assign ack_data = (state_q == ACK) ? fifo_rdata : '0;
    assign busy     = (state_q != IDLE);

endmodule
